set_bit_iterator: RTL and testbench
===================================

# set_bit_iterator

Sequential drain of a bit vector: accepts a WIDTH-bit vector over a valid/ready load handshake, then emits each set bit on a valid/ready output stream, one per handshake, lowest index first. Each output beat carries the bit as a one-hot vector and as a binary index. It is the streaming consumer side of the combinational first-one operation: an arbiter or scheduler hands it a request mask, and downstream logic receives the requests one at a time. It sits between mask-producing logic and per-request service logic.

## Interface
- WIDTH, 8, width of the loaded vector; must be ≥ 2.
- INDEX_WIDTH, $clog2(WIDTH), width of the binary index output; derived, not overridden.
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- load_data  input  WIDTH  vector to iterate.
- load_valid  input  1  load_data is valid.
- load_ready  output  1  block accepts a load this cycle.
- abort  input  1  synchronous discard of the current iteration.
- out_one_hot  output  WIDTH  lowest remaining set bit, one-hot.
- out_index  output  INDEX_WIDTH  binary index of out_one_hot.
- out_last  output  1  out_one_hot is the last remaining set bit.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts the beat.
- done  output  1  one-cycle pulse when an iteration completes.

## Operation
- Internal state: remaining register (WIDTH bits); state machine with states IDLE and ITERATE.
- IDLE:
  - load_ready = 1; out_valid = 0.
  - On load_valid with a non-zero load_data: remaining ← load_data; go to ITERATE.
  - On load_valid with load_data = 0: stay in IDLE; done pulses on the next cycle; no beat is emitted.
- ITERATE:
  - load_ready = 0; out_valid = 1.
  - out_one_hot = remaining & (~remaining + 1).
  - out_index = log2(out_one_hot).
  - out_last = 1 when exactly one bit of remaining is set.
  - On out_valid && out_ready: remaining ← remaining & ~out_one_hot.
  - If out_last was 1 on that handshake, go to IDLE and pulse done on the next cycle.
- While out_valid = 1 and out_ready = 0, out_one_hot, out_index and out_last hold stable. Valid is never dropped without a handshake, except by abort or reset.
- abort:
  - In any state: remaining ← 0 and state ← IDLE on the next edge. No done pulse.
  - abort has priority over a simultaneous output handshake or load; a simultaneous load is discarded.
- In IDLE, out_one_hot, out_index and out_last are 0.

## Timing
- Reset values: state IDLE, remaining 0, load_ready 1, out_valid 0, out_one_hot 0, out_index 0, out_last 0, done 0.
- Reset asserted mid-iteration returns the block to the reset values on the next edge. Reset has priority over abort and over all handshakes.
- Load latency: a load accepted at edge N gives out_valid = 1 from cycle N+1.
- Throughput: one beat per cycle while out_ready = 1. A vector with k set bits drains in k cycles.
- done is asserted during the cycle after the edge that accepts the last beat, coincident with load_ready returning to 1.
- For a zero load, done is asserted in the cycle after acceptance.
- No new load overlaps an active iteration. Back-to-back minimum: the last beat at edge M allows the next load at edge M+1 and its first beat in cycle M+2.
- All outputs are functions of registered state only. There is no combinational path from load_valid, out_ready or abort to any output.

## Test plan
- **Full drain, WIDTH=8:** load 8'b1010_0110 with out_ready held at 1.
  - Required beats: one-hot 00000010 / index 1, 00000100 / index 2, 00100000 / index 5, 10000000 / index 7 with out_last = 1.
  - done pulses one cycle after the last beat; load_ready returns to 1.
- **Backpressure:** load 8'b1000_0001 with out_ready = 0 for 3 cycles.
  - Beat 00000001 / index 0 holds for 3 cycles, then completes; beat index 7 follows with out_last = 1.
- **Zero and single-bit loads:**
  - Load 8'h00: no out_valid; done pulses the next cycle.
  - Load 8'h80: one beat, index 7, out_last = 1.
- **Abort:** load 8'hFF, accept 2 beats, assert abort.
  - Next cycle: out_valid = 0, load_ready = 1, no done pulse.
  - A following load of 8'h01 yields a single beat, index 0.
- **Reset mid-iteration:** load 8'hF0, accept 1 beat, assert reset.
  - All outputs at their reset values the next cycle; a load presented during reset is ignored.
- **Exhaustive:** all 256 load values with random out_ready.
  - Emitted indices must be strictly ascending and must equal the set bits of the loaded vector.
  - out_last must be set only on the final beat.
  - Beat count must equal popcount of the loaded vector.

Source files
------------

// File: rtl/set_bit_iterator.sv
// set_bit_iterator: accepts a bit vector over a load handshake and streams its
// set bits out one per handshake, lowest index first, as one-hot and index.
//
//  state   | meaning
//  --------+------------------------------------------------------------
//  IDLE    | waiting for a load; load_ready high, no output beat
//  ITERATE | presenting the lowest remaining set bit until it is accepted
module set_bit_iterator #(
  parameter int WIDTH = 8,
  localparam int INDEX_WIDTH = $clog2(WIDTH)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       load_data,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic                   abort,
  output logic [WIDTH-1:0]       out_one_hot,
  output logic [INDEX_WIDTH-1:0] out_index,
  output logic                   out_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   done
);

  typedef enum logic {
    IDLE    = 1'b0,
    ITERATE = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] remaining_q;
  logic [WIDTH-1:0] remaining_d;
  logic             done_d;

  // Lowest set bit and single-bit detect, derived from registered state only.
  logic [WIDTH-1:0] lowest_bit;
  logic             single_bit;

  assign lowest_bit = remaining_q & (~remaining_q + ONE);
  assign single_bit = (remaining_q != '0) && ((remaining_q & (remaining_q - ONE)) == '0);

  // State, remaining mask and done pulse registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      done        <= done_d;
    end
  end

  // Next-state, next-mask and done decisions; abort wins over any handshake.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    if (abort) begin
      state_d     = IDLE;
      remaining_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (load_valid) begin
            if (load_data != '0) begin
              remaining_d = load_data;
              state_d     = ITERATE;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        ITERATE: begin
          if (out_ready) begin
            remaining_d = remaining_q & ~lowest_bit;
            if (single_bit) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
        default: begin
          state_d     = IDLE;
          remaining_d = '0;
        end
      endcase
    end
  end

  // Outputs: handshake flags from state, beat contents gated to ITERATE.
  always_comb begin
    load_ready  = (state_q == IDLE);
    out_valid   = (state_q == ITERATE);
    out_one_hot = '0;
    out_index   = '0;
    out_last    = 1'b0;
    if (state_q == ITERATE) begin
      out_one_hot = lowest_bit;
      out_last    = single_bit;
      for (int i = 0; i < WIDTH; i++) begin
        if (lowest_bit[i]) begin
          out_index = i[INDEX_WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_set_bit_iterator.sv
// Directed and randomized bench for set_bit_iterator: a queue of expected set
// indices per loaded vector is compared beat by beat against the DUT.
module tb_set_bit_iterator;

  localparam int WIDTH = 8;
  localparam int IW    = 3;

  logic             clock = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] load_data;
  logic             load_valid;
  logic             load_ready;
  logic             abort;
  logic [WIDTH-1:0] out_one_hot;
  logic [IW-1:0]    out_index;
  logic             out_last;
  logic             out_valid;
  logic             out_ready;
  logic             done;

  int n_checks = 0;
  int n_fail   = 0;

  set_bit_iterator #(.WIDTH(WIDTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .load_data  (load_data),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .abort      (abort),
    .out_one_hot(out_one_hot),
    .out_index  (out_index),
    .out_last   (out_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .done       (done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_load_ready"}, 32'(load_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_one_hot"}, 32'(out_one_hot), 32'd0);
    check({tag, "_index"}, 32'(out_index), 32'd0);
    check({tag, "_last"}, 32'(out_last), 32'd0);
  endtask

  // Called at a negedge with the DUT idle. mode 0: out_ready always 1,
  // mode 1: random out_ready, mode 2: out_ready low for the first 3 cycles.
  task automatic drain(input logic [WIDTH-1:0] vec, input int mode, input string tag);
    int exp_q[$];
    int cyc;
    logic r;
    for (int i = 0; i < WIDTH; i++) if (vec[i]) exp_q.push_back(i);
    check({tag, "_pre_ready"}, 32'(load_ready), 32'd1);
    load_valid = 1'b1;
    load_data  = vec;
    out_ready  = 1'b1;
    @(negedge clock);
    load_valid = 1'b0;
    load_data  = $urandom;
    if (exp_q.size() == 0) begin
      check({tag, "_zero_done"}, 32'(done), 32'd1);
      check_idle_outputs({tag, "_zero"});
      return;
    end
    cyc = 0;
    while (exp_q.size() > 0) begin
      if (cyc > 60) begin
        check({tag, "_timeout"}, 32'(exp_q.size()), 32'd0);
        return;
      end
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_ready_low"}, 32'(load_ready), 32'd0);
      check({tag, "_one_hot"}, 32'(out_one_hot), 32'd1 << exp_q[0]);
      check({tag, "_index"}, 32'(out_index), 32'(exp_q[0]));
      check({tag, "_last"}, 32'(out_last), 32'(exp_q.size() == 1));
      check({tag, "_no_done"}, 32'(done), 32'd0);
      case (mode)
        0:       r = 1'b1;
        1:       r = (cyc > 40) ? 1'b1 : 1'($urandom_range(0, 1));
        default: r = (cyc >= 3);
      endcase
      out_ready = r;
      @(negedge clock);
      if (r) void'(exp_q.pop_front());
      cyc++;
    end
    out_ready = 1'b0;
    check({tag, "_done"}, 32'(done), 32'd1);
    check_idle_outputs({tag, "_end"});
  endtask

  initial begin
    reset      = 1'b1;
    load_data  = '0;
    load_valid = 1'b0;
    abort      = 1'b0;
    out_ready  = 1'b0;
    repeat (2) @(negedge clock);
    check_idle_outputs("reset");
    check("reset_done", 32'(done), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    drain(8'b1010_0110, 0, "full");
    @(negedge clock);
    check("full_done_pulse_end", 32'(done), 32'd0);

    drain(8'b1000_0001, 2, "bp");
    drain(8'h00, 0, "zero");
    @(negedge clock);
    check("zero_done_pulse_end", 32'(done), 32'd0);
    drain(8'h80, 0, "single");

    // Abort after two beats of 8'hFF; a simultaneous load must be discarded.
    load_valid = 1'b1;
    load_data  = 8'hFF;
    @(negedge clock);
    load_valid = 1'b0;
    out_ready  = 1'b1;
    repeat (2) @(negedge clock);
    check("abort_pre_index", 32'(out_index), 32'd2);
    abort      = 1'b1;
    load_valid = 1'b1;
    load_data  = 8'h3C;
    @(negedge clock);
    abort      = 1'b0;
    load_valid = 1'b0;
    out_ready  = 1'b0;
    check_idle_outputs("abort");
    check("abort_no_done", 32'(done), 32'd0);
    @(negedge clock);
    check("abort_no_done2", 32'(done), 32'd0);
    check("abort_still_idle", 32'(out_valid), 32'd0);
    drain(8'h01, 0, "post_abort");

    // Reset mid-iteration with a load presented during reset.
    @(negedge clock);
    load_valid = 1'b1;
    load_data  = 8'hF0;
    @(negedge clock);
    load_valid = 1'b0;
    out_ready  = 1'b1;
    @(negedge clock);
    check("rst_mid_index", 32'(out_index), 32'd5);
    reset      = 1'b1;
    load_valid = 1'b1;
    load_data  = 8'h55;
    @(negedge clock);
    load_valid = 1'b0;
    out_ready  = 1'b0;
    check_idle_outputs("rst_mid");
    check("rst_mid_done", 32'(done), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check_idle_outputs("rst_after");
    check("rst_after_done", 32'(done), 32'd0);

    for (int v = 0; v < 256; v++) drain(8'(v), 1, "exh");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
